// File: rtl/mdc_hamming_frontend.sv
// Hamming-protected frame input stage for the MDC determinant core.
// Decodes one Hamming(9,5) mode word per frame and FRAME_LEN Hamming(15,11)
// data words. It corrects single-bit errors when CORR_EN=1 and emits a
// registered, indexed element stream.
module mdc_hamming_frontend #(
    parameter int unsigned FRAME_LEN = 16,
    parameter bit          CORR_EN   = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [8:0]                    in_mode,
    input  logic [14:0]                   in_data,
    output logic                          dec_valid,
    output logic                          dec_start,
    output logic                          dec_last,
    output logic [$clog2(FRAME_LEN)-1:0]  dec_idx,
    output logic [10:0]                   dec_data,
    output logic [4:0]                    dec_mode,
    output logic                          corr_flag,
    output logic                          mode_err,
    output logic                          frame_err
);

    localparam int unsigned       IDX_W    = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0]  IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(32'd1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(FRAME_LEN - 32'd1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } state_t;

    // Position p (1-based) lives at cw[15-p]; syndrome is the XOR of set positions.
    function automatic logic [3:0] data_syndrome(input logic [14:0] cw);
        logic [3:0] syn;
        syn = 4'd0;
        for (int p = 1; p <= 15; p++) begin
            if (cw[4'(15 - p)] == 1'b1) begin
                syn = syn ^ 4'(p);
            end else begin
                syn = syn;
            end
        end
        return syn;
    endfunction

    // Position p (1-based) lives at cw[9-p].
    function automatic logic [3:0] mode_syndrome(input logic [8:0] cw);
        logic [3:0] syn;
        syn = 4'd0;
        for (int p = 1; p <= 9; p++) begin
            if (cw[4'(9 - p)] == 1'b1) begin
                syn = syn ^ 4'(p);
            end else begin
                syn = syn;
            end
        end
        return syn;
    endfunction

    // Any nonzero syndrome points inside the 15-bit codeword, so it is always fixable.
    function automatic logic [14:0] data_correct(input logic [14:0] cw, input logic [3:0] syn);
        logic [14:0] fixed;
        fixed = cw;
        if ((CORR_EN == 1'b1) && (syn != 4'd0)) begin
            fixed[4'd15 - syn] = ~cw[4'd15 - syn];
        end else begin
            fixed = cw;
        end
        return fixed;
    endfunction

    // Syndromes 10..15 point outside the 9-bit codeword and are left alone.
    function automatic logic [8:0] mode_correct(input logic [8:0] cw, input logic [3:0] syn);
        logic [8:0] fixed;
        fixed = cw;
        if ((CORR_EN == 1'b1) && (syn != 4'd0) && (syn <= 4'd9)) begin
            fixed[4'd9 - syn] = ~cw[4'd9 - syn];
        end else begin
            fixed = cw;
        end
        return fixed;
    endfunction

    // Data bits MSB-first from positions 3,5,6,7,9..15.
    function automatic logic [10:0] data_extract(input logic [14:0] cw);
        return {cw[12], cw[10], cw[9], cw[8], cw[6:0]};
    endfunction

    // Mode bits MSB-first from positions 3,5,6,7,9.
    function automatic logic [4:0] mode_extract(input logic [8:0] cw);
        return {cw[6], cw[4], cw[3], cw[2], cw[0]};
    endfunction

    state_t             state_r;
    state_t             state_nx_s;
    logic [IDX_W-1:0]   cnt_r;
    logic [IDX_W-1:0]   cnt_nx_s;

    logic [3:0]         data_syn_s;
    logic [3:0]         mode_syn_s;
    logic [10:0]        data_dec_s;
    logic [4:0]         mode_dec_s;
    logic               mode_bad_s;

    logic               valid_nx_s;
    logic               start_nx_s;
    logic               last_nx_s;
    logic [IDX_W-1:0]   idx_nx_s;
    logic [10:0]        data_nx_s;
    logic [4:0]         mode_nx_s;
    logic               corr_nx_s;
    logic               merr_nx_s;
    logic               ferr_nx_s;

    // Decode the current input words.
    always_comb begin
        data_syn_s = data_syndrome(in_data);
        mode_syn_s = mode_syndrome(in_mode);
        data_dec_s = data_extract(data_correct(in_data, data_syn_s));
        mode_dec_s = mode_extract(mode_correct(in_mode, mode_syn_s));
        mode_bad_s = (mode_syn_s > 4'd9);
    end

    // Frame sequencing: next state, word counter and next output values.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        valid_nx_s = 1'b0;
        start_nx_s = 1'b0;
        last_nx_s  = 1'b0;
        idx_nx_s   = IDX_ZERO;
        data_nx_s  = 11'd0;
        corr_nx_s  = 1'b0;
        mode_nx_s  = dec_mode;
        merr_nx_s  = mode_err;
        ferr_nx_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (in_valid == 1'b1) begin
                    valid_nx_s = 1'b1;
                    start_nx_s = 1'b1;
                    last_nx_s  = (LAST_IDX == IDX_ZERO);
                    idx_nx_s   = IDX_ZERO;
                    data_nx_s  = data_dec_s;
                    corr_nx_s  = (data_syn_s != 4'd0);
                    mode_nx_s  = mode_dec_s;
                    merr_nx_s  = mode_bad_s;
                    cnt_nx_s   = IDX_ONE;
                    state_nx_s = ST_RECV;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RECV: begin
                if (in_valid == 1'b1) begin
                    valid_nx_s = 1'b1;
                    last_nx_s  = (cnt_r == LAST_IDX);
                    idx_nx_s   = cnt_r;
                    data_nx_s  = data_dec_s;
                    corr_nx_s  = (data_syn_s != 4'd0);
                    cnt_nx_s   = cnt_r + IDX_ONE;
                    if (cnt_r == LAST_IDX) begin
                        state_nx_s = ST_IDLE;
                    end else begin
                        state_nx_s = ST_RECV;
                    end
                end else begin
                    // Frame ended short; words already emitted stay emitted.
                    ferr_nx_s  = 1'b1;
                    cnt_nx_s   = IDX_ZERO;
                    state_nx_s = ST_IDLE;
                end
            end
            default: begin
                cnt_nx_s   = IDX_ZERO;
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst == 1'b1) begin
            state_r   <= ST_IDLE;
            cnt_r     <= IDX_ZERO;
            dec_valid <= 1'b0;
            dec_start <= 1'b0;
            dec_last  <= 1'b0;
            dec_idx   <= IDX_ZERO;
            dec_data  <= 11'd0;
            dec_mode  <= 5'd0;
            corr_flag <= 1'b0;
            mode_err  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            cnt_r     <= cnt_nx_s;
            dec_valid <= valid_nx_s;
            dec_start <= start_nx_s;
            dec_last  <= last_nx_s;
            dec_idx   <= idx_nx_s;
            dec_data  <= data_nx_s;
            dec_mode  <= mode_nx_s;
            corr_flag <= corr_nx_s;
            mode_err  <= merr_nx_s;
            frame_err <= ferr_nx_s;
        end
    end

endmodule
